// File: rtl/datamem_pkg.sv
// Shared definitions for the byte-addressable RISC-V data memory LSU.
// Holds the funct3 size/sign codes and the request FSM state type.
package datamem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/datamem_lsu_if.sv
// Request/response valid-ready bundle between the MEM stage and the data memory.
interface datamem_lsu_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/datamem_align.sv
// Byte-lane steering for stores, sign/zero extension for loads, and
// detection of illegal funct3 codes and misaligned addresses.
module datamem_align
  import datamem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte   = rword[{addr_lo, 3'b000} +: 8];
    sel_half   = addr_lo[1] ? rword[31:16] : rword[15:0];
    be         = 4'b0000;
    wdata_lane = '0;
    rdata_ext  = '0;
    err        = 1'b0;
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{sel_byte[7]}}, sel_byte};
      end
      F3_BU: begin
        err       = we;
        rdata_ext = {24'h0, sel_byte};
      end
      F3_H: begin
        err        = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{sel_half[15]}}, sel_half};
      end
      F3_HU: begin
        err       = we | addr_lo[0];
        rdata_ext = {16'h0, sel_half};
      end
      F3_W: begin
        err        = (addr_lo != 2'b00);
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      default: err = 1'b1;
    endcase
    // Loads and faulting accesses never touch the array.
    if (err || !we) be = 4'b0000;
  end

endmodule

// File: rtl/datamem_lsu.sv
// MEM-stage data memory: one outstanding request, fixed LATENCY from accept to
// response, byte-lane stores and extended loads on a 32-bit word array.
module datamem_lsu
  import datamem_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 'h0000_1000,
  parameter int unsigned              DEPTH_WORDS   = 1024,
  parameter int unsigned              LATENCY       = 1
) (
  input logic          clk,
  input logic          rst,
  datamem_lsu_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [ADDRESS_WIDTH:0] Limit = (ADDRESS_WIDTH + 1)'(4 * DEPTH_WORDS);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("datamem_lsu: DATA_WIDTH must be 32");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("datamem_lsu: LATENCY must be in 1..8");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("datamem_lsu: DEPTH_WORDS must be a power of two >= 2");
  end

  state_e                   state_q;
  logic [2:0]               cnt_q;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     resp_valid_q;
  logic                     resp_err_q;
  logic [DATA_WIDTH-1:0]    resp_rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [ADDRESS_WIDTH-1:0] off;
  logic                     in_range;
  logic [IdxW-1:0]          idx;
  logic [31:0]              rword;
  logic [3:0]               be;
  logic [31:0]              wdata_lane;
  logic [31:0]              rdata_ext;
  logic                     align_err;
  logic                     acc_err;
  logic                     commit;

  // Offset compare is one bit wider so BASE_ADDR + 4*DEPTH_WORDS cannot wrap.
  always_comb begin
    off      = addr_q - BASE_ADDR;
    in_range = (addr_q >= BASE_ADDR) && ({1'b0, off} < Limit);
    idx      = off[IdxW+1:2];
    rword    = mem[idx];
    acc_err  = align_err | ~in_range;
    commit   = (state_q == WAIT) && (cnt_q == 3'd0);
  end

  datamem_align u_align (
    .funct3     (f3_q),
    .we         (we_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rword      (rword),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .err        (align_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= 3'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err;
            resp_rdata_q <= (we_q || acc_err) ? '0 : rdata_ext;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && we_q && !acc_err && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE) && !rst;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_datamem_lsu.sv
// Bench for datamem_lsu: one instance at LATENCY=1 and one at LATENCY=4, checked
// against a byte-array reference model plus directed vectors and corner sequences.
module tb_datamem_lsu;
  import datamem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  datamem_lsu_if bus1 ();
  datamem_lsu_if bus4 ();

  logic        rv[2], rwe[2], rr[2];
  logic [2:0]  rf3[2];
  logic [31:0] ra[2], rwd[2];
  logic        o_rdy[2], o_vld[2], o_err[2];
  logic [31:0] o_rd[2];

  assign bus1.req_valid  = rv[0];
  assign bus1.req_we     = rwe[0];
  assign bus1.req_funct3 = rf3[0];
  assign bus1.req_addr   = ra[0];
  assign bus1.req_wdata  = rwd[0];
  assign bus1.resp_ready = rr[0];
  assign o_rdy[0]        = bus1.req_ready;
  assign o_vld[0]        = bus1.resp_valid;
  assign o_err[0]        = bus1.resp_err;
  assign o_rd[0]         = bus1.resp_rdata;

  assign bus4.req_valid  = rv[1];
  assign bus4.req_we     = rwe[1];
  assign bus4.req_funct3 = rf3[1];
  assign bus4.req_addr   = ra[1];
  assign bus4.req_wdata  = rwd[1];
  assign bus4.resp_ready = rr[1];
  assign o_rdy[1]        = bus4.req_ready;
  assign o_vld[1]        = bus4.resp_valid;
  assign o_err[1]        = bus4.resp_err;
  assign o_rd[1]         = bus4.resp_rdata;

  datamem_lsu #(.LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  datamem_lsu #(.LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int tests = 0;
  int fails = 0;
  int lat_of[2];
  logic [7:0] mb[2][4096];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: little-endian byte array over [0x1000, 0x2000).
  function automatic void model(input int w, input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic e);
    int unsigned size;
    bit legal;
    int offi;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e     = !legal || (a % size != 0) || (a < 32'h1000) || (a >= 32'h2000);
    rd    = '0;
    if (e) return;
    offi = int'(a - 32'h1000);
    if (we) begin
      for (int i = 0; i < int'(size); i++) mb[w][offi+i] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(size); i++) v[8*i +: 8] = mb[w][offi+i];
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8 * size)) - 32'h1);
      rd = v;
    end
  endfunction

  task automatic xact(input int w, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input int stall, input logic [31:0] exp_rd,
                      input logic exp_e, output logic [31:0] rd, output logic e,
                      output int lat);
    int n = 0;
    @(negedge clk);
    rv[w] = 1'b1; rwe[w] = we; rf3[w] = f3; ra[w] = a; rwd[w] = d;
    while (!o_rdy[w] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("req_ready_timeout", o_rdy[w], 1);
      rv[w] = 1'b0; rd = '0; e = 1'b0; lat = -1;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble request fields after acceptance; they must be ignored.
    rv[w] = 1'b0; rwe[w] = 1'($urandom); rf3[w] = 3'($urandom);
    ra[w] = $urandom; rwd[w] = $urandom; rr[w] = (stall == 0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!o_vld[w] && lat < 20);
    rd = o_rd[w];
    e  = o_err[w];
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", o_vld[w], 1);
      chk("hold_rdata", o_rd[w], exp_rd);
      chk("hold_err", o_err[w], exp_e);
    end
    rr[w] = 1'b1;
    @(posedge clk);
    #1;
    chk("resp_valid_drop", o_vld[w], 0);
  endtask

  task automatic run(input string nm, input int w, input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d, input int stall);
    logic [31:0] exp_rd, rd;
    logic exp_e, e;
    int lat;
    model(w, we, f3, a, d, exp_rd, exp_e);
    xact(w, we, f3, a, d, stall, exp_rd, exp_e, rd, e, lat);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, e, exp_e);
    chk({nm, "_latency"}, lat, lat_of[w]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    logic [31:0] rd, mrd;
    logic e, me;
    int lat, n;
    lat_of[0] = 1;
    lat_of[1] = 4;
    for (int w = 0; w < 2; w++) begin
      rv[w] = 1'b0; rwe[w] = 1'b0; rf3[w] = 3'd0; ra[w] = '0; rwd[w] = '0; rr[w] = 1'b1;
    end
    rst = 1'b1;

    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst_req_ready", o_rdy[w], 0);
      chk("rst_resp_valid", o_vld[w], 0);
      chk("rst_resp_rdata", o_rd[w], 0);
      chk("rst_resp_err", o_err[w], 0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_ready1", o_rdy[0], 1);
    chk("post_rst_ready4", o_rdy[1], 1);

    // Give both arrays known contents so the model covers every word.
    for (int i = 0; i < 1024; i++) begin
      run("prefill1", 0, 1'b1, F3_W, 32'h1000 + 32'(4 * i), 32'h0, 0);
      run("prefill4", 1, 1'b1, F3_W, 32'h1000 + 32'(4 * i), 32'h0, 0);
    end

    vt.push_back(vec_t'{1'b1, F3_W,  32'h1000, 32'hDEADBEEF, 32'h0,        1'b0});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h1000, 32'h0,        32'hDEADBEEF, 1'b0});
    vt.push_back(vec_t'{1'b1, F3_W,  32'h1004, 32'h80FF7F01, 32'h0,        1'b0});
    vt.push_back(vec_t'{1'b0, F3_B,  32'h1007, 32'h0,        32'hFFFFFF80, 1'b0});
    vt.push_back(vec_t'{1'b0, F3_BU, 32'h1007, 32'h0,        32'h00000080, 1'b0});
    vt.push_back(vec_t'{1'b0, F3_H,  32'h1006, 32'h0,        32'hFFFF80FF, 1'b0});
    vt.push_back(vec_t'{1'b0, F3_HU, 32'h1004, 32'h0,        32'h00007F01, 1'b0});
    vt.push_back(vec_t'{1'b0, F3_B,  32'h1004, 32'h0,        32'h00000001, 1'b0});
    vt.push_back(vec_t'{1'b1, F3_W,  32'h1008, 32'h0,        32'h0,        1'b0});
    vt.push_back(vec_t'{1'b1, F3_B,  32'h100A, 32'hFFFFFFAB, 32'h0,        1'b0});
    vt.push_back(vec_t'{1'b1, F3_H,  32'h1008, 32'hFFFF1234, 32'h0,        1'b0});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h1008, 32'h0,        32'h00AB1234, 1'b0});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h1002, 32'h0,        32'h0,        1'b1});
    vt.push_back(vec_t'{1'b1, F3_W,  32'h0FFC, 32'h11111111, 32'h0,        1'b1});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h0FFC, 32'h0,        32'h0,        1'b1});
    vt.push_back(vec_t'{1'b0, 3'd3,  32'h1000, 32'h0,        32'h0,        1'b1});
    vt.push_back(vec_t'{1'b1, F3_W,  32'h1010, 32'hCAFEF00D, 32'h0,        1'b0});
    vt.push_back(vec_t'{1'b1, F3_H,  32'h1011, 32'hFFFFFFFF, 32'h0,        1'b1});
    vt.push_back(vec_t'{1'b0, F3_W,  32'h1010, 32'h0,        32'hCAFEF00D, 1'b0});
    vt.push_back(vec_t'{1'b1, 3'd3,  32'h1010, 32'h0,        32'h0,        1'b1});
    vt.push_back(vec_t'{1'b1, F3_W,  32'h2000, 32'h12345678, 32'h0,        1'b1});
    vt.push_back(vec_t'{1'b1, F3_W,  32'h1FFC, 32'h89ABCDEF, 32'h0,        1'b0});
    vt.push_back(vec_t'{1'b0, F3_HU, 32'h1FFE, 32'h0,        32'h000089AB, 1'b0});
    vt.push_back(vec_t'{1'b0, F3_BU, 32'h1FFF, 32'h0,        32'h00000089, 1'b0});
    for (int i = 0; i < vt.size(); i++) begin
      model(0, vt[i].we, vt[i].f3, vt[i].a, vt[i].d, mrd, me);
      xact(0, vt[i].we, vt[i].f3, vt[i].a, vt[i].d, 0, vt[i].exp_rd, vt[i].exp_e, rd, e, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), e, vt[i].exp_e);
      chk($sformatf("vec%0d_latency", i), lat, 1);
    end

    // LATENCY=4 with the consumer stalling for five cycles.
    run("bp_store", 1, 1'b1, F3_W, 32'h1100, 32'h12345678, 0);
    @(negedge clk);
    rv[1] = 1'b1; rwe[1] = 1'b0; rf3[1] = F3_W; ra[1] = 32'h1100; rr[1] = 1'b0;
    @(posedge clk);
    #1;
    rv[1] = 1'b0; ra[1] = 32'h1000;
    chk("bp_wait_ready", o_rdy[1], 0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!o_vld[1] && n < 20);
    chk("bp_latency", n, 4);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("bp_valid", o_vld[1], 1);
      chk("bp_rdata", o_rd[1], 32'h12345678);
      chk("bp_err", o_err[1], 0);
      chk("bp_req_ready", o_rdy[1], 0);
    end
    rr[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_ready", o_rdy[1], 1);
    chk("bp_release_valid", o_vld[1], 0);

    // Reset while a store is waiting for its commit edge: it must vanish.
    run("rst_prior", 1, 1'b1, F3_W, 32'h1010, 32'h0BADF00D, 0);
    @(negedge clk);
    rv[1] = 1'b1; rwe[1] = 1'b1; rf3[1] = F3_W; ra[1] = 32'h1010; rwd[1] = 32'h55;
    @(posedge clk);
    #1;
    rv[1] = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_wait_ready", o_rdy[1], 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", o_vld[1], 0);
    chk("mid_rst_ready", o_rdy[1], 0);
    repeat (4) @(negedge clk);
    chk("mid_rst_hold_valid", o_vld[1], 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_release_ready", o_rdy[1], 1);
    run("rst_after", 1, 1'b0, F3_W, 32'h1010, 32'h0, 0);

    for (int i = 0; i < 400; i++) begin
      int w, r, stall;
      logic we;
      logic [2:0] f3;
      logic [31:0] a;
      logic [2:0] legal_f3[5];
      legal_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
      w     = $urandom_range(0, 1);
      we    = 1'($urandom_range(0, 1));
      f3    = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
      r     = $urandom_range(0, 9);
      stall = $urandom_range(0, 2);
      case (r)
        0:       a = $urandom;
        1:       a = 32'h0FF0 + 32'($urandom_range(0, 31));
        2:       a = 32'h1FF0 + 32'($urandom_range(0, 31));
        default: a = 32'h1000 + 32'($urandom_range(0, 255));
      endcase
      run("rand", w, we, f3, a, $urandom, stall);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
